// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared defaults and types for the FIFO read streamer
package fifo_stream_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    // Occupancy of the 2-entry output buffer, 0..2
    typedef logic [1:0] buf_cnt_t;

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - 2-entry circular output buffer with head pointer
module skid_buf2
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output buf_cnt_t          cnt,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    buf_cnt_t          cnt_q, cnt_d;
    logic              head_q, head_d;
    logic              pop_ok;
    logic              tail;
    logic [DATA_W-1:0] mem_q [2];

    // The tail is head^cnt[0] even on a same-cycle pop: the freed slot is
    // the old head only when the buffer was full, which is exactly cnt=2.
    always_comb begin
        pop_ok   = pop && (cnt_q != 2'd0);
        tail     = head_q ^ cnt_q[0];
        cnt_d    = cnt_q + buf_cnt_t'(push) - buf_cnt_t'(pop_ok);
        head_d   = head_q ^ pop_ok;
        cnt       = cnt_q;
        out_valid = (cnt_q != 2'd0);
        out_data  = mem_q[head_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            head_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail] <= push_data;
        end
    end

endmodule

// File: rtl/fifo_read_streamer.sv
// rtl/fifo_read_streamer.sv - async FIFO read master re-presenting words as a valid/ready stream
module fifo_read_streamer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              read_clk,
    input  logic              read_rst_n,
    input  logic              p_read_empty,
    input  logic [DATA_W-1:0] p_read_data,
    output logic              p_read_en,
    input  logic              halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_idle,
    output logic [CNT_W-1:0]  xfer_count
);

    logic             en_pre_q, en_pre_d;
    logic             en_ok_q, en_ok_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic             pop;
    logic [2:0]       occ_after;
    buf_cnt_t         buf_cnt;

    skid_buf2 #(.DATA_W(DATA_W)) u_buf (
        .clk       (read_clk),
        .rst_n     (read_rst_n),
        .push      (inflight_q),
        .push_data (p_read_data),
        .pop       (pop),
        .cnt       (buf_cnt),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // A new read is only issued if the word it returns is guaranteed a slot
    // once this cycle's pop and the in-flight word are accounted for.
    always_comb begin
        pop        = out_valid && out_ready;
        occ_after  = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
        p_read_en  = read_rst_n && en_ok_q && !halt && !p_read_empty
                     && (occ_after <= 3'd1);
        en_pre_d   = 1'b1;
        en_ok_d    = en_pre_q;
        inflight_d = p_read_en;
        xfer_d     = xfer_q + CNT_W'(pop);
        out_idle   = (buf_cnt == 2'd0) && !inflight_q;
        xfer_count = xfer_q;
    end

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            en_pre_q   <= 1'b0;
            en_ok_q    <= 1'b0;
            inflight_q <= 1'b0;
            xfer_q     <= '0;
        end else begin
            en_pre_q   <= en_pre_d;
            en_ok_q    <= en_ok_d;
            inflight_q <= inflight_d;
            xfer_q     <= xfer_d;
        end
    end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb/tb_fifo_read_streamer.sv - directed bench for fifo_read_streamer with a registered FIFO model
module tb_fifo_read_streamer;

    logic        read_clk = 1'b0;
    logic        read_rst_n = 1'b0;
    logic        p_read_empty = 1'b0;
    logic [7:0]  p_read_data = 8'h00;
    logic        halt = 1'b0;
    logic        out_ready = 1'b0;
    logic        p_read_en, out_valid, out_idle;
    logic [7:0]  out_data;
    logic [15:0] xfer_count;
    logic        p_read_en4, out_valid4, out_idle4;
    logic [7:0]  out_data4;
    logic [3:0]  xfer_count4;

    fifo_read_streamer #(.DATA_W(8), .CNT_W(16)) u_dut (
        .read_clk(read_clk), .read_rst_n(read_rst_n), .p_read_empty(p_read_empty),
        .p_read_data(p_read_data), .p_read_en(p_read_en), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idle(out_idle), .xfer_count(xfer_count)
    );

    fifo_read_streamer #(.DATA_W(8), .CNT_W(4)) u_dut_w4 (
        .read_clk(read_clk), .read_rst_n(read_rst_n), .p_read_empty(p_read_empty),
        .p_read_data(p_read_data), .p_read_en(p_read_en4), .halt(halt),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_idle(out_idle4), .xfer_count(xfer_count4)
    );

    always #5 read_clk = ~read_clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         cyc = 0, en_cnt = 0, pop_cnt = 0, occ = 0;
    int         first_en_cyc = -1, first_val_cyc = -1, first_pop_cyc = -1, last_pop_cyc = -1;
    logic [7:0] last_pop_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        fifo_q.push_back(d);
        p_read_empty = 1'b0;
    endtask

    // Called at posedge+1; samples mid-cycle, advances the FIFO model across the edge.
    task automatic step();
        logic       en, pop;
        logic [7:0] rd;
        #3;
        en  = p_read_en;
        pop = out_valid && out_ready;
        chk("en_while_empty", 32'(en && p_read_empty), 32'd0);
        if (en && first_en_cyc < 0) first_en_cyc = cyc;
        if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 32'd1, 32'd0);
            end else begin
                chk("stream_data", 32'(out_data), 32'(exp_q[0]));
                chk("stream_data_w4", 32'(out_data4), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc  = cyc;
            last_pop_data = out_data;
            pop_cnt++;
        end
        rd = p_read_data;
        if (en) begin
            if (fifo_q.size() != 0) begin
                rd = fifo_q.pop_front();
                exp_q.push_back(rd);
            end
            en_cnt++;
        end
        occ = occ + int'(en) - int'(pop);
        chk("occupancy_le2", 32'(occ <= 2), 32'd1);
        @(posedge read_clk);
        #1;
        p_read_data  = rd;
        p_read_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic run_pops(input int target, input int budget);
        int n;
        n = 0;
        while (pop_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk("pops_reached", 32'(pop_cnt), 32'(target));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int base, pushed, e0, p0;
        for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
        @(posedge read_clk); #1;
        @(posedge read_clk); #1;
        chk("rst_en", 32'(p_read_en), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_idle", 32'(out_idle), 32'd1);
        chk("rst_xfer", 32'(xfer_count), 32'd0);
        chk("rst_idle_w4", 32'(out_idle4 && !out_valid4 && !p_read_en4), 32'd1);

        read_rst_n = 1'b1;
        out_ready  = 1'b1;
        #1;
        chk("en_at_release", 32'(p_read_en), 32'd0);
        step();
        chk("en_after_edge1", 32'(p_read_en), 32'd0);
        step();
        chk("en_after_edge2", 32'(p_read_en), 32'd1);
        run_pops(16, 60);
        chk("first_valid_lat", 32'(first_val_cyc - first_en_cyc), 32'd2);
        chk("one_per_cycle", 32'(last_pop_cyc - first_pop_cyc), 32'd15);
        chk("stream_xfer", 32'(xfer_count), 32'd16);
        chk("stream_idle", 32'(out_idle), 32'd1);

        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i));
        e0 = en_cnt;
        repeat (10) step();
        chk("bp_reads", 32'(en_cnt - e0), 32'd2);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_head", 32'(out_data), 32'hA0);
        out_ready = 1'b1;
        run_pops(24, 40);
        chk("bp_xfer", 32'(xfer_count), 32'd24);

        base = pop_cnt;
        pushed = 0;
        for (int n = 0; n < 20000 && pop_cnt < base + 1000; n++) begin
            if (pushed < 1000 && $urandom_range(2) != 0) begin
                push_word(8'(pushed));
                pushed++;
            end
            out_ready = 1'($urandom_range(1));
            step();
        end
        chk("rand_pops", 32'(pop_cnt), 32'(base + 1000));
        chk("rand_xfer", 32'(xfer_count), 32'd1024);
        chk("rand_idle", 32'(out_idle), 32'd1);

        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'hB0 + 8'(i));
        step();
        step();
        e0 = en_cnt;
        p0 = pop_cnt;
        halt = 1'b1;
        out_ready = 1'b1;
        repeat (5) step();
        chk("halt_no_reads", 32'(en_cnt - e0), 32'd0);
        chk("halt_drained", 32'(pop_cnt - p0), 32'd2);
        chk("halt_idle", 32'(out_idle), 32'd1);
        halt = 1'b0;
        run_pops(p0 + 6, 40);

        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'hC0 + 8'(i));
        repeat (4) step();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #3;
        read_rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(p_read_en), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_idle", 32'(out_idle), 32'd1);
        chk("arst_xfer", 32'(xfer_count), 32'd0);
        exp_q.delete();
        occ = 0;
        @(posedge read_clk); #1;
        read_rst_n = 1'b1;
        out_ready  = 1'b1;
        for (int i = 0; i < 11; i++) push_word(8'hD0 + 8'(i));
        base = pop_cnt;
        run_pops(base + 1, 20);
        chk("post_rst_head", 32'(last_pop_data), 32'hC2);
        run_pops(base + 17, 60);
        chk("wrap_xfer16", 32'(xfer_count), 32'd17);
        chk("wrap_xfer4", 32'(xfer_count4), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
